// File: rtl/axi_write_route_ctrl2x2_pkg.sv
// axi_write_route_ctrl2x2_pkg: state codes, sizes and arbitration helper shared by the write-route controller
package axi_write_route_ctrl2x2_pkg;
  localparam int NUM_M = 2;
  localparam int NUM_S = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  // A lone requester wins outright; a tie goes to the master that did not win last.
  function automatic logic rr_pick(input logic [NUM_M-1:0] req, input logic last);
    return (&req) ? ~last : req[1];
  endfunction
endpackage

// File: rtl/axi_write_route_ctrl2x2_if.sv
// axi_write_route_ctrl2x2_if: AXI handshake observation inputs and mux control outputs of the write-route controller
interface axi_write_route_ctrl2x2_if #(parameter int ADDR_WIDTH = 32);
  logic                  M0_AWVALID, M1_AWVALID;
  logic [ADDR_WIDTH-1:0] M0_AWADDR, M1_AWADDR;
  logic S0_AWVALID, S0_AWREADY, S0_WVALID, S0_WREADY, S0_WLAST, S0_BVALID, S0_BREADY;
  logic S1_AWVALID, S1_AWREADY, S1_WVALID, S1_WREADY, S1_WLAST, S1_BVALID, S1_BREADY;
  logic M0_write_addr_sel, M0_write_addr_en, M0_write_data_sel, M0_write_data_en;
  logic M1_write_addr_sel, M1_write_addr_en, M1_write_data_sel, M1_write_data_en;
  logic S0_write_resp_sel, S0_write_resp_en, S1_write_resp_sel, S1_write_resp_en;
  modport slave (
    input  M0_AWVALID, M0_AWADDR, M1_AWVALID, M1_AWADDR,
    input  S0_AWVALID, S0_AWREADY, S0_WVALID, S0_WREADY, S0_WLAST, S0_BVALID, S0_BREADY,
    input  S1_AWVALID, S1_AWREADY, S1_WVALID, S1_WREADY, S1_WLAST, S1_BVALID, S1_BREADY,
    output M0_write_addr_sel, M0_write_addr_en, M0_write_data_sel, M0_write_data_en,
    output M1_write_addr_sel, M1_write_addr_en, M1_write_data_sel, M1_write_data_en,
    output S0_write_resp_sel, S0_write_resp_en, S1_write_resp_sel, S1_write_resp_en
  );
  modport master (
    output M0_AWVALID, M0_AWADDR, M1_AWVALID, M1_AWADDR,
    output S0_AWVALID, S0_AWREADY, S0_WVALID, S0_WREADY, S0_WLAST, S0_BVALID, S0_BREADY,
    output S1_AWVALID, S1_AWREADY, S1_WVALID, S1_WREADY, S1_WLAST, S1_BVALID, S1_BREADY,
    input  M0_write_addr_sel, M0_write_addr_en, M0_write_data_sel, M0_write_data_en,
    input  M1_write_addr_sel, M1_write_addr_en, M1_write_data_sel, M1_write_data_en,
    input  S0_write_resp_sel, S0_write_resp_en, S1_write_resp_sel, S1_write_resp_en
  );
endinterface

// File: rtl/axi_write_route_ctrl2x2_fsm.sv
// axi_wr_slave_fsm: per-slave transaction FSM holding one master from AW grant through the B handshake
module axi_wr_slave_fsm
  import axi_write_route_ctrl2x2_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM_M-1:0] req_i,
  input  logic             aw_hs_i,
  input  logic             w_last_hs_i,
  input  logic             b_hs_i,
  output logic [1:0]       state_o,
  output logic             mst_o
);
  logic [1:0] state_q, state_d;
  logic       mst_q, mst_d, last_q, last_d;
  always_comb begin
    state_d = state_q;
    mst_d   = mst_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: if (|req_i) begin
        state_d = ST_ADDR;
        mst_d   = rr_pick(req_i, last_q);
        last_d  = mst_d;
      end
      ST_ADDR: state_d = aw_hs_i ? ST_DATA : ST_ADDR;
      ST_DATA: state_d = w_last_hs_i ? ST_RESP : ST_DATA;
      default: state_d = b_hs_i ? ST_IDLE : ST_RESP;
    endcase
  end
  // last_q resets to M1 so that M0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mst_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      mst_q   <= mst_d;
      last_q  <= last_d;
    end
  end
  assign state_o = state_q;
  assign mst_o   = mst_q;
endmodule

// File: rtl/axi_write_route_ctrl2x2.sv
// axi_write_route_ctrl2x2: decodes AW targets, locks busy masters and merges per-slave FSMs into mux controls
module axi_write_route_ctrl2x2
  import axi_write_route_ctrl2x2_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEC_BIT    = 31
) (
  input logic                      ACLK,
  input logic                      ARESETn,
  axi_write_route_ctrl2x2_if.slave bus
);
  logic [ADDR_WIDTH-1:0] awaddr_unused [NUM_M];
  logic [NUM_M-1:0] awv, tgt, lock, ae, as, de, ds;
  logic [NUM_S-1:0] aw_hs, w_hs, b_hs, mst, in_addr, in_data, in_resp, busy;
  logic [1:0]       st  [NUM_S];
  logic [NUM_M-1:0] req [NUM_S];
  assign awaddr_unused[0] = bus.M0_AWADDR;
  assign awaddr_unused[1] = bus.M1_AWADDR;
  assign awv   = {bus.M1_AWVALID, bus.M0_AWVALID};
  assign tgt   = {awaddr_unused[1][DEC_BIT], awaddr_unused[0][DEC_BIT]};
  assign aw_hs = {bus.S1_AWVALID & bus.S1_AWREADY, bus.S0_AWVALID & bus.S0_AWREADY};
  assign w_hs  = {bus.S1_WVALID & bus.S1_WREADY & bus.S1_WLAST, bus.S0_WVALID & bus.S0_WREADY & bus.S0_WLAST};
  assign b_hs  = {bus.S1_BVALID & bus.S1_BREADY, bus.S0_BVALID & bus.S0_BREADY};
  for (genvar s = 0; s < NUM_S; s++) begin : g_s
    assign in_addr[s] = st[s] == ST_ADDR;
    assign in_data[s] = st[s] == ST_DATA;
    assign in_resp[s] = st[s] == ST_RESP;
    assign busy[s]    = st[s] != ST_IDLE;
    assign req[s]     = awv & ~lock & (s ? tgt : ~tgt);
    axi_wr_slave_fsm u_fsm (
      .clk        (ACLK),
      .rst_n      (ARESETn),
      .req_i      (req[s]),
      .aw_hs_i    (aw_hs[s]),
      .w_last_hs_i(w_hs[s]),
      .b_hs_i     (b_hs[s]),
      .state_o    (st[s]),
      .mst_o      (mst[s])
    );
  end
  // Each master decodes to one slave, so at most one slave FSM owns it per phase
  for (genvar m = 0; m < NUM_M; m++) begin : g_m
    logic [NUM_S-1:0] own;
    assign own     = {mst[1] == 1'(m), mst[0] == 1'(m)};
    assign lock[m] = |(busy & own);
    assign ae[m]   = |(in_addr & own);
    assign as[m]   = in_addr[1] & own[1];
    assign de[m]   = |(in_data & own);
    assign ds[m]   = in_data[1] & own[1];
  end
  assign bus.M0_write_addr_en  = ae[0];
  assign bus.M0_write_addr_sel = as[0];
  assign bus.M0_write_data_en  = de[0];
  assign bus.M0_write_data_sel = ds[0];
  assign bus.M1_write_addr_en  = ae[1];
  assign bus.M1_write_addr_sel = as[1];
  assign bus.M1_write_data_en  = de[1];
  assign bus.M1_write_data_sel = ds[1];
  assign bus.S0_write_resp_en  = in_resp[0];
  assign bus.S0_write_resp_sel = in_resp[0] & mst[0];
  assign bus.S1_write_resp_en  = in_resp[1];
  assign bus.S1_write_resp_sel = in_resp[1] & mst[1];
endmodule

// File: tb/tb_axi_write_route_ctrl2x2.sv
// tb_axi_write_route_ctrl2x2: directed plus random stimulus checked against a transaction-level route model
module tb_axi_write_route_ctrl2x2;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int checks = 0;
  int errors = 0;
  int ph [2];
  int own [2];
  int last [2];

  always #5 ACLK = ~ACLK;

  axi_write_route_ctrl2x2_if #(.ADDR_WIDTH(32)) bus ();
  axi_write_route_ctrl2x2 #(.ADDR_WIDTH(32), .DEC_BIT(31)) dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic bit awv(int m);
    return m ? bus.M1_AWVALID : bus.M0_AWVALID;
  endfunction
  function automatic int tgt(int m);
    return m ? int'(bus.M1_AWADDR[31]) : int'(bus.M0_AWADDR[31]);
  endfunction
  function automatic bit awhs(int s);
    return s ? (bus.S1_AWVALID && bus.S1_AWREADY) : (bus.S0_AWVALID && bus.S0_AWREADY);
  endfunction
  function automatic bit wlhs(int s);
    return s ? (bus.S1_WVALID && bus.S1_WREADY && bus.S1_WLAST) : (bus.S0_WVALID && bus.S0_WREADY && bus.S0_WLAST);
  endfunction
  function automatic bit bhs(int s);
    return s ? (bus.S1_BVALID && bus.S1_BREADY) : (bus.S0_BVALID && bus.S0_BREADY);
  endfunction

  function automatic logic dae(int m); return m ? bus.M1_write_addr_en  : bus.M0_write_addr_en;  endfunction
  function automatic logic das(int m); return m ? bus.M1_write_addr_sel : bus.M0_write_addr_sel; endfunction
  function automatic logic dde(int m); return m ? bus.M1_write_data_en  : bus.M0_write_data_en;  endfunction
  function automatic logic dds(int m); return m ? bus.M1_write_data_sel : bus.M0_write_data_sel; endfunction
  function automatic logic dre(int s); return s ? bus.S1_write_resp_en  : bus.S0_write_resp_en;  endfunction
  function automatic logic drs(int s); return s ? bus.S1_write_resp_sel : bus.S0_write_resp_sel; endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Model: phase 0 free, 1 address, 2 data, 3 response; own = master holding the slave
  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin ph[s] = 0; own[s] = 0; last[s] = 1; end
  endtask

  task automatic model_step();
    bit lk [2];
    bit w [2];
    int nph [2];
    int nown [2];
    int g;
    for (int m = 0; m < 2; m++) begin
      lk[m] = 0;
      for (int s = 0; s < 2; s++) if (ph[s] != 0 && own[s] == m) lk[m] = 1;
    end
    for (int s = 0; s < 2; s++) begin
      nph[s] = ph[s];
      nown[s] = own[s];
      if (ph[s] == 0) begin
        for (int m = 0; m < 2; m++) w[m] = awv(m) && tgt(m) == s && !lk[m];
        g = (w[0] && w[1]) ? 1 - last[s] : w[0] ? 0 : w[1] ? 1 : -1;
        if (g >= 0) begin nph[s] = 1; nown[s] = g; last[s] = g; end
      end else if (ph[s] == 1 && awhs(s)) nph[s] = 2;
      else if (ph[s] == 2 && wlhs(s)) nph[s] = 3;
      else if (ph[s] == 3 && bhs(s)) nph[s] = 0;
    end
    for (int s = 0; s < 2; s++) begin ph[s] = nph[s]; own[s] = nown[s]; end
  endtask

  task automatic check_all(input string tag);
    logic ea, sa, ed, sd;
    for (int m = 0; m < 2; m++) begin
      ea = 0; sa = 0; ed = 0; sd = 0;
      for (int s = 0; s < 2; s++) begin
        if (ph[s] == 1 && own[s] == m) begin ea = 1; sa = 1'(s); end
        if (ph[s] == 2 && own[s] == m) begin ed = 1; sd = 1'(s); end
      end
      chk($sformatf("%s M%0d addr_en", tag, m), dae(m), ea);
      if (ea) chk($sformatf("%s M%0d addr_sel", tag, m), das(m), sa);
      chk($sformatf("%s M%0d data_en", tag, m), dde(m), ed);
      if (ed) chk($sformatf("%s M%0d data_sel", tag, m), dds(m), sd);
    end
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("%s S%0d resp_en", tag, s), dre(s), ph[s] == 3);
      if (ph[s] == 3) chk($sformatf("%s S%0d resp_sel", tag, s), drs(s), 1'(own[s]));
    end
  endtask

  task automatic step(input string tag);
    @(posedge ACLK);
    model_step();
    #1;
    check_all(tag);
    @(negedge ACLK);
  endtask

  task automatic m_req(input int m, input bit v, input logic [31:0] a);
    if (m != 0) begin bus.M1_AWVALID = v; bus.M1_AWADDR = a; end
    else begin bus.M0_AWVALID = v; bus.M0_AWADDR = a; end
  endtask

  task automatic s_set(input int s, input bit aw, input bit w, input bit wl, input bit b);
    if (s != 0) begin
      bus.S1_AWVALID = aw; bus.S1_AWREADY = aw; bus.S1_WVALID = w; bus.S1_WREADY = w;
      bus.S1_WLAST = wl; bus.S1_BVALID = b; bus.S1_BREADY = b;
    end else begin
      bus.S0_AWVALID = aw; bus.S0_AWREADY = aw; bus.S0_WVALID = w; bus.S0_WREADY = w;
      bus.S0_WLAST = wl; bus.S0_BVALID = b; bus.S0_BREADY = b;
    end
  endtask

  task automatic idle_all();
    m_req(0, 0, 32'h0);
    m_req(1, 0, 32'h0);
    s_set(0, 0, 0, 0, 0);
    s_set(1, 0, 0, 0, 0);
  endtask

  task automatic finish_txn(input int s, input int m, input string tag);
    s_set(s, 1, 0, 0, 0);
    step({tag, " aw"});
    m_req(m, 0, 32'h0);
    s_set(s, 0, 1, 1, 0);
    step({tag, " wlast"});
    s_set(s, 0, 0, 0, 1);
    step({tag, " b"});
    s_set(s, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    model_reset();
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  initial begin
    int beats;
    bit wr;
    idle_all();
    model_reset();
    repeat (3) @(negedge ACLK);
    #1;
    check_all("reset");
    chk("reset M0 addr_sel", bus.M0_write_addr_sel, 1'b0);
    chk("reset S1 resp_sel", bus.S1_write_resp_sel, 1'b0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // single transaction M0 -> S0
    m_req(0, 1, 32'h0000_1000);
    step("t2 grant");
    chk("t2 M0 addr_en", bus.M0_write_addr_en, 1'b1);
    chk("t2 M0 addr_sel", bus.M0_write_addr_sel, 1'b0);
    finish_txn(0, 0, "t2");
    step("t2 idle");

    // asynchronous reset in the middle of a data phase
    m_req(0, 1, 32'h0000_1000);
    step("t1 grant");
    s_set(0, 1, 0, 0, 0);
    step("t1 aw");
    chk("t1 M0 data_en before reset", bus.M0_write_data_en, 1'b1);
    idle_all();
    #2 ARESETn = 1'b0;
    model_reset();
    #1;
    check_all("t1 async");
    chk("t1 M0 data_en in reset", bus.M0_write_data_en, 1'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // tie on S0 after reset: M0 first, then M1, then M0 again
    m_req(0, 1, 32'h0000_0010);
    m_req(1, 1, 32'h0000_0020);
    step("t3 tie1");
    chk("t3 M0 first", bus.M0_write_addr_en, 1'b1);
    chk("t3 M1 waits", bus.M1_write_addr_en, 1'b0);
    finish_txn(0, 0, "t3 m0");
    step("t3 m1 grant");
    chk("t3 M1 granted", bus.M1_write_addr_en, 1'b1);
    finish_txn(0, 1, "t3 m1");
    m_req(0, 1, 32'h0000_0010);
    m_req(1, 1, 32'h0000_0020);
    step("t3 tie2");
    chk("t3 M0 after rr", bus.M0_write_addr_en, 1'b1);
    finish_txn(0, 0, "t3 m0b");
    step("t3 m1b grant");
    finish_txn(0, 1, "t3 m1b");
    step("t3 idle");

    // disjoint targets granted on the same edge
    m_req(0, 1, 32'h8000_0000);
    m_req(1, 1, 32'h0000_0000);
    step("t4 grant");
    chk("t4 M0 addr_en", bus.M0_write_addr_en, 1'b1);
    chk("t4 M0 addr_sel", bus.M0_write_addr_sel, 1'b1);
    chk("t4 M1 addr_en", bus.M1_write_addr_en, 1'b1);
    chk("t4 M1 addr_sel", bus.M1_write_addr_sel, 1'b0);
    s_set(0, 1, 0, 0, 0);
    s_set(1, 1, 0, 0, 0);
    step("t4 aw");
    idle_all();
    s_set(0, 0, 1, 1, 0);
    s_set(1, 0, 1, 1, 0);
    step("t4 w");
    s_set(0, 0, 0, 0, 1);
    s_set(1, 0, 0, 0, 1);
    step("t4 b");
    idle_all();
    step("t4 idle");

    // 4-beat burst to S1 with WREADY toggling
    m_req(1, 1, 32'h8000_0000);
    step("t5 grant");
    s_set(1, 1, 0, 0, 0);
    step("t5 aw");
    idle_all();
    beats = 0;
    for (int c = 0; c < 12 && beats < 4; c++) begin
      wr = (c % 2) == 0;
      bus.S1_WVALID = 1'b1;
      bus.S1_WREADY = wr;
      bus.S1_WLAST = beats == 3;
      step("t5 beat");
      chk("t5 M1 data_en", bus.M1_write_data_en, !(wr && beats == 3));
      if (wr) beats++;
    end
    s_set(1, 0, 0, 0, 1);
    step("t5 b");
    idle_all();

    // AWVALID dropped during the address phase: grant held
    m_req(0, 1, 32'h0000_0040);
    step("t6 grant");
    m_req(0, 0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      step("t6 hold");
      chk("t6 M0 addr_en held", bus.M0_write_addr_en, 1'b1);
    end
    finish_txn(0, 0, "t6");
    step("t6 idle");

    // random traffic with independent valid/ready on both sides
    for (int i = 0; i < 600; i++) begin
      m_req(0, 1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 31'($urandom)});
      m_req(1, 1'($urandom_range(0, 1)), {1'($urandom_range(0, 1)), 31'($urandom)});
      {bus.S0_AWVALID, bus.S0_AWREADY, bus.S0_WVALID, bus.S0_WREADY, bus.S0_WLAST, bus.S0_BVALID, bus.S0_BREADY} = 7'($urandom);
      {bus.S1_AWVALID, bus.S1_AWREADY, bus.S1_WVALID, bus.S1_WREADY, bus.S1_WLAST, bus.S1_BVALID, bus.S1_BREADY} = 7'($urandom);
      if (i == 300) do_reset();
      step("rnd");
    end
    idle_all();
    step("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
